// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and
// a saturating count of inserted bubbles.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_uses_rt_i,
  input  logic [15:0] id_imm_i,
  input  logic [31:0] id_read_data1_i,
  input  logic [31:0] id_read_data2_i,
  input  logic        id_reg_write_i,
  input  logic        id_mem_read_i,
  input  logic        id_mem_write_i,
  input  logic        id_mem_to_reg_i,
  input  logic        id_alu_src_i,
  input  logic        id_reg_dst_i,
  input  logic [3:0]  id_alu_op_i,
  input  logic        flush_i,
  input  logic        ex_hold_i,
  output logic        ex_valid_o,
  output logic [4:0]  ex_rs_o,
  output logic [4:0]  ex_rt_o,
  output logic [4:0]  ex_write_reg_o,
  output logic [31:0] ex_imm_o,
  output logic [31:0] ex_read_data1_o,
  output logic [31:0] ex_read_data2_o,
  output logic        ex_reg_write_o,
  output logic        ex_mem_read_o,
  output logic        ex_mem_write_o,
  output logic        ex_mem_to_reg_o,
  output logic        ex_alu_src_o,
  output logic [3:0]  ex_alu_op_o,
  output logic        stall_o,
  output logic [15:0] bubble_count_o
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  write_reg;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
  } ex_t;

  ex_t         ex_q, ex_d, load_w;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        hz;

  always_comb begin
    hz = ex_q.valid & ex_q.mem_read & id_valid_i & (ex_q.write_reg != 5'd0) &
         ((ex_q.write_reg == id_rs_i) | (id_uses_rt_i & (ex_q.write_reg == id_rt_i)));
    stall_o = (hz | ex_hold_i) & ~flush_i;
  end

  // Control is masked by id_valid so a non-valid slot can never write state.
  always_comb begin
    load_w            = '0;
    load_w.valid      = id_valid_i;
    load_w.rs         = id_rs_i;
    load_w.rt         = id_rt_i;
    load_w.write_reg  = id_reg_dst_i ? id_rd_i : id_rt_i;
    load_w.imm        = {{16{id_imm_i[15]}}, id_imm_i};
    load_w.rd1        = id_read_data1_i;
    load_w.rd2        = id_read_data2_i;
    load_w.reg_write  = id_valid_i & id_reg_write_i;
    load_w.mem_read   = id_valid_i & id_mem_read_i;
    load_w.mem_write  = id_valid_i & id_mem_write_i;
    load_w.mem_to_reg = id_valid_i & id_mem_to_reg_i;
    load_w.alu_src    = id_valid_i & id_alu_src_i;
    load_w.alu_op     = id_valid_i ? id_alu_op_i : 4'd0;
  end

  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (ex_hold_i) begin
      ex_d = ex_q;
    end else if (hz) begin
      ex_d = '0;
      if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else begin
      ex_d = load_w;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_rs_o         = ex_q.rs;
  assign ex_rt_o         = ex_q.rt;
  assign ex_write_reg_o  = ex_q.write_reg;
  assign ex_imm_o        = ex_q.imm;
  assign ex_read_data1_o = ex_q.rd1;
  assign ex_read_data2_o = ex_q.rd2;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign bubble_count_o  = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the MIPS pipelined processor. Sits directly downstream of the register file:
- Captures the two read operands, which the register file drives on the falling edge, at the next rising edge, together with decoded fields and control.
- Presents all of these to the EX stage.
- Detects load-use hazards, inserts bubbles, stalls IF/ID and honours branch flushes.
- Keeps a saturating count of inserted bubbles.

## Interface
- No parameters.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  input  5 each  register specifiers from decode.
- id_uses_rt  input  1  instruction reads rt as a source operand.
- id_imm  input  16  raw immediate field.
- id_read_data1, id_read_data2  input  32 each  register file outputs for rs/rt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  input  1 each  decoded control.
- id_alu_op  input  4  ALU operation code.
- flush  input  1  branch taken in EX; squash ID.
- ex_hold  input  1  downstream stall; freeze this register.
- ex_valid  output  1  EX holds a real instruction.
- ex_rs, ex_rt  output  5 each  registered specifiers (for forwarding).
- ex_write_reg  output  5  destination: id_rd if id_reg_dst=1, else id_rt; captured at load.
- ex_imm  output  32  sign-extended id_imm.
- ex_read_data1, ex_read_data2  output  32 each  registered operands.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  output  1 each.
- ex_alu_op  output  4.
- stall  output  1  combinational; hold PC and IF/ID this cycle.
- bubble_count  output  16  saturating count of load-use bubbles.

## Operation
- Hazard condition (combinational), hz = ex_valid & ex_mem_read & id_valid & (ex_write_reg != 0) & ((ex_write_reg == id_rs) | (id_uses_rt & (ex_write_reg == id_rt))).
- stall = (hz | ex_hold) & ~flush.
- Rising-edge action, highest priority first:
  1. rst: asynchronous clear. Every output register is 0, including ex_valid, all control, data, specifiers and bubble_count. stall is 0 after reset.
  2. flush: load a bubble.
  3. ex_hold: all registers keep their value; bubble_count is unchanged.
  4. hz: load a bubble; bubble_count increments, saturating at 0xFFFF.
  5. Otherwise: load all id_* values. ex_valid = id_valid. ex_imm = {{16{id_imm[15]}}, id_imm}.
- Bubble: ex_valid=0, all six control outputs 0, ex_alu_op=0, ex_rs/ex_rt/ex_write_reg=0, ex_imm=0, ex_read_data1/2=0.
- When id_valid=0 and none of flush, ex_hold or hz applies, the stage loads normally. Control outputs are then forced to 0, so that a non-valid instruction never writes.
- Register $0 never triggers a hazard.

## Timing
- Latency: one cycle from ID inputs to ex_* outputs.
- id_read_data1/2 are stable from the preceding falling edge and are sampled at the rising edge.
- A register file write at rising edge N is visible to ID reads at falling edge N, so this stage needs no WB-to-ID bypass.
- Load-use hazard costs exactly one bubble:
  - Cycle N: hz=1 and stall=1, so IF/ID holds and a bubble enters EX.
  - Cycle N+1: ex_valid=0, so hz=0 and the dependent instruction loads.
- flush and hz in the same cycle: bubble with no count increment; stall=0.
- flush and ex_hold in the same cycle: flush wins.
- ex_hold and hz in the same cycle: hold wins, with no count increment. stall stays 1.
- Reset asserted mid-stall: outputs clear immediately, without waiting for a clock edge. stall drops once ex_valid=0.

## Test plan
- Reset: assert rst asynchronously between edges -> all outputs 0 immediately; stall=0; bubble_count=0.
- Straight-line load: id_valid=1, id_rs=2, id_rt=5, id_rd=7, id_reg_dst=1, id_imm=0x8001, data 0x11/0x22 -> next edge: ex_write_reg=7, ex_imm=0xFFFF8001, ex_read_data1=0x11, ex_read_data2=0x22.
- Load-use: lw into $4 in EX (ex_mem_read=1, ex_write_reg=4); ID has id_rs=4 -> stall=1 and one bubble (ex_valid=0); bubble_count=1. Next cycle stall=0 and the instruction loads. Repeat with ex_write_reg=0 -> no stall.
- Hazard on rt only: lw into $6; ID has id_rt=6 with id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall.
- Priority: flush with hz -> bubble, count unchanged. ex_hold=1 for 3 cycles -> outputs frozen, stall=1. flush with ex_hold -> bubble.
- Saturation: force 65537 hazard cycles -> bubble_count stops at 0xFFFF.
